simulator_resonant: RTL and testbench

SIMULATOR_RESONANT -- requirements
Module: simulator_resonant

---
 rtl/simulator_resonant.sv | 161 ++++++++++++++++
 tb/tb_simulator_resonant.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/simulator_resonant.sv
// rtl/simulator_resonant.sv - fixed-point Euler integrator for an LLC / series-LC resonant tank
//
// Ports:
//   CLK        sole clock, rising edge
//   RESET      asynchronous, active-high; returns to IDLE with all state zeroed
//   EN         step enable while in RUN
//   START      request IDLE -> RUN
//   STOP       request RUN -> IDLE (state held, step counter held)
//   CLR_FAULT  FAULT -> IDLE, zeroes state and step counter
//   sigma      switching input: 01 = +1, 11 = -1, 00/10 = 0
//   vC_p, iS_p, Vo_p  registered signed state values (W bits)
//   VALID      one-cycle strobe on the step that wraps the decimation counter
//   RUNNING    state == RUN
//   FAULT      state == FAULT
module simulator_resonant #(
  parameter int                 W     = 32,
  parameter int                 MODE  = 0,
  parameter logic signed [31:0] MU_1  = 32'sd12,
  parameter logic signed [31:0] MU_2  = -32'sd1,
  parameter logic signed [31:0] MU_3  = 32'sd48000,
  parameter logic signed [31:0] MU_4  = -32'sd10,
  parameter logic signed [31:0] MU_5  = -32'sd1675,
  parameter logic signed [31:0] MU_6  = 32'sd480,
  parameter int                 SH_1  = 20,
  parameter int                 SH_4  = 10,
  parameter int                 SH_5  = 17,
  parameter int                 DECIM = 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                EN,
  input  logic                START,
  input  logic                STOP,
  input  logic                CLR_FAULT,
  input  logic [1:0]          sigma,
  output logic signed [W-1:0] vC_p,
  output logic signed [W-1:0] iS_p,
  output logic signed [W-1:0] Vo_p,
  output logic                VALID,
  output logic                RUNNING,
  output logic                FAULT
);

  localparam int SW = W + 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  localparam logic [15:0] LAST = 16'(DECIM - 1);

  localparam logic signed [63:0] MU1_64 = {{32{MU_1[31]}}, MU_1};
  localparam logic signed [63:0] MU2_64 = {{32{MU_2[31]}}, MU_2};
  localparam logic signed [63:0] MU3_64 = {{32{MU_3[31]}}, MU_3};
  localparam logic signed [63:0] MU4_64 = {{32{MU_4[31]}}, MU_4};
  localparam logic signed [63:0] MU5_64 = {{32{MU_5[31]}}, MU_5};
  localparam logic signed [63:0] MU6_64 = {{32{MU_6[31]}}, MU_6};

  logic [1:0]  state;
  logic [15:0] cnt;

  logic signed [63:0] s64, vc64, is64, vo64;
  logic signed [63:0] p_vc, p_is_a, p_is_b, p_vo_a, p_vo_b, p_vo_c;
  logic signed [SW-1:0] sum_vc, sum_is, sum_vo;
  logic [W:0] sat_vc, sat_is, sat_vo;
  logic ovf_any;
  logic step;

  // Clip a W+8 bit sum to W bits. The sum fits iff all bits from the
  // sign bit of the W-bit result upward agree. Returns {overflow, value}.
  function automatic logic [W:0] sat(input logic [SW-1:0] x);
    logic [SW-W:0] top;
    top = x[SW-1:W-1];
    if ((&top) || !(|top))
      sat = {1'b0, x[W-1:0]};
    else
      sat = {1'b1, x[SW-1], {(W-1){~x[SW-1]}}};
  endfunction

  always_comb begin
    case (sigma)
      2'b01:   s64 = 64'sd1;
      2'b11:   s64 = -64'sd1;
      default: s64 = 64'sd0;
    endcase

    vc64 = {{(64-W){vC_p[W-1]}}, vC_p};
    is64 = {{(64-W){iS_p[W-1]}}, iS_p};
    vo64 = {{(64-W){Vo_p[W-1]}}, Vo_p};

    // vC + Vo cannot exceed W+1 bits, so forming it at 64 bits is exact.
    p_vc   = (MU1_64 * is64) >>> SH_1;
    p_is_a = MU2_64 * ((MODE == 1) ? vc64 : (vc64 + vo64));
    p_is_b = MU3_64 * s64;
    p_vo_a = (MU4_64 * vc64) >>> SH_4;
    p_vo_b = (MU5_64 * vo64) >>> SH_5;
    p_vo_c = MU6_64 * s64;

    sum_vc = SW'(vc64) + SW'(p_vc);
    sum_is = SW'(is64) + SW'(p_is_a) + SW'(p_is_b);
    sum_vo = SW'(vo64) + SW'(p_vo_a) + SW'(p_vo_b) + SW'(p_vo_c);

    sat_vc = sat(sum_vc);
    sat_is = sat(sum_is);
    // The series-LC tank has no load capacitor; Vo is pinned at zero.
    sat_vo = (MODE == 1) ? '0 : sat(sum_vo);

    ovf_any = sat_vc[W] | sat_is[W] | sat_vo[W];
  end

  assign step    = (state == S_RUN) && EN && !STOP;
  assign RUNNING = (state == S_RUN);
  assign FAULT   = (state == S_FAULT);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
      cnt   <= '0;
      vC_p  <= '0;
      iS_p  <= '0;
      Vo_p  <= '0;
      VALID <= 1'b0;
    end else begin
      VALID <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) state <= S_RUN;
        end
        S_RUN: begin
          if (STOP) begin
            state <= S_IDLE;
          end else if (step) begin
            vC_p <= sat_vc[W-1:0];
            iS_p <= sat_is[W-1:0];
            Vo_p <= sat_vo[W-1:0];
            // A saturating step stores the clipped values but produces no sample.
            if (ovf_any) begin
              state <= S_FAULT;
            end else if (cnt == LAST) begin
              cnt   <= '0;
              VALID <= 1'b1;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        S_FAULT: begin
          if (CLR_FAULT) begin
            state <= S_IDLE;
            cnt   <= '0;
            vC_p  <= '0;
            iS_p  <= '0;
            Vo_p  <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simulator_resonant.sv
// tb/tb_simulator_resonant.sv - self-checking bench for simulator_resonant
module tb_simulator_resonant;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Default-parameter instance, driven from the vector table.
  logic d_rst, d_en, d_start, d_stop, d_clr;
  logic [1:0] d_sigma;
  logic signed [31:0] d_vc, d_is, d_vo;
  logic d_valid, d_running, d_fault;

  // Shared stimulus for the parameterised instances.
  logic b_rst, b_en, b_start, b_stop, b_clr;
  logic [1:0] b_sigma;

  logic signed [31:0] q_vc, q_is, q_vo;
  logic q_valid, q_running, q_fault;
  logic signed [15:0] n_vc, n_is, n_vo;
  logic n_valid, n_running, n_fault;
  logic signed [31:0] m_vc, m_is, m_vo;
  logic m_valid, m_running, m_fault;

  simulator_resonant dut_d (
    .CLK(CLK), .RESET(d_rst), .EN(d_en), .START(d_start), .STOP(d_stop),
    .CLR_FAULT(d_clr), .sigma(d_sigma), .vC_p(d_vc), .iS_p(d_is), .Vo_p(d_vo),
    .VALID(d_valid), .RUNNING(d_running), .FAULT(d_fault));

  simulator_resonant #(.DECIM(4)) dut_q (
    .CLK(CLK), .RESET(b_rst), .EN(b_en), .START(b_start), .STOP(b_stop),
    .CLR_FAULT(b_clr), .sigma(b_sigma), .vC_p(q_vc), .iS_p(q_is), .Vo_p(q_vo),
    .VALID(q_valid), .RUNNING(q_running), .FAULT(q_fault));

  simulator_resonant #(.W(16)) dut_n (
    .CLK(CLK), .RESET(b_rst), .EN(b_en), .START(b_start), .STOP(b_stop),
    .CLR_FAULT(b_clr), .sigma(b_sigma), .vC_p(n_vc), .iS_p(n_is), .Vo_p(n_vo),
    .VALID(n_valid), .RUNNING(n_running), .FAULT(n_fault));

  simulator_resonant #(.MODE(1)) dut_m (
    .CLK(CLK), .RESET(b_rst), .EN(b_en), .START(b_start), .STOP(b_stop),
    .CLR_FAULT(b_clr), .sigma(b_sigma), .vC_p(m_vc), .iS_p(m_is), .Vo_p(m_vo),
    .VALID(m_valid), .RUNNING(m_running), .FAULT(m_fault));

  typedef struct {
    logic       rst, start, stop, en;
    logic [1:0] sigma;
    longint     vc, i_s, vo;
    logic       valid, running, fault;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic b_restart();
    @(negedge CLK);
    b_rst = 1'b1; b_en = 1'b0; b_start = 1'b0; b_stop = 1'b0; b_clr = 1'b0; b_sigma = 2'b01;
    @(negedge CLK);
    b_rst = 1'b0; b_start = 1'b1;
    @(negedge CLK);
    b_start = 1'b0;
  endtask

  initial begin
    d_rst = 1'b1; d_en = 1'b0; d_start = 1'b0; d_stop = 1'b0; d_clr = 1'b0; d_sigma = 2'b00;
    b_rst = 1'b1; b_en = 1'b0; b_start = 1'b0; b_stop = 1'b0; b_clr = 1'b0; b_sigma = 2'b00;

    //        rst start stop en sigma   vC   iS      Vo    valid run fault
    vt[0]  = '{0, 0, 0, 1, 2'b01,  0,      0,    0, 0, 0, 0};
    vt[1]  = '{0, 1, 0, 0, 2'b01,  0,      0,    0, 0, 1, 0};
    vt[2]  = '{0, 0, 0, 1, 2'b01,  0,  48000,  480, 1, 1, 0};
    vt[3]  = '{0, 0, 0, 1, 2'b01,  0,  95520,  953, 1, 1, 0};
    vt[4]  = '{0, 0, 0, 0, 2'b01,  0,  95520,  953, 0, 1, 0};
    vt[5]  = '{0, 1, 1, 1, 2'b01,  0,  95520,  953, 0, 0, 0};
    vt[6]  = '{0, 0, 0, 1, 2'b01,  0,  95520,  953, 0, 0, 0};
    vt[7]  = '{1, 0, 0, 0, 2'b00,  0,      0,    0, 0, 0, 0};
    vt[8]  = '{0, 1, 0, 0, 2'b00,  0,      0,    0, 0, 1, 0};
    vt[9]  = '{0, 0, 0, 1, 2'b10,  0,      0,    0, 1, 1, 0};
    vt[10] = '{0, 0, 0, 1, 2'b11,  0, -48000, -480, 1, 1, 0};
    vt[11] = '{0, 0, 0, 1, 2'b00, -1, -47520, -474, 1, 1, 0};
    vt[12] = '{0, 0, 0, 1, 2'b00, -2, -47045, -468, 1, 1, 0};

    @(negedge CLK);
    chk("reset vC", d_vc, 0);
    chk("reset iS", d_is, 0);
    chk("reset valid", d_valid, 0);
    chk("reset fault", d_fault, 0);
    d_rst = 1'b0;
    b_rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(negedge CLK);
      d_rst = vt[i].rst; d_start = vt[i].start; d_stop = vt[i].stop;
      d_en = vt[i].en; d_sigma = vt[i].sigma;
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d vC", i), d_vc, vt[i].vc);
      chk($sformatf("vec%0d iS", i), d_is, vt[i].i_s);
      chk($sformatf("vec%0d Vo", i), d_vo, vt[i].vo);
      chk($sformatf("vec%0d VALID", i), d_valid, vt[i].valid);
      chk($sformatf("vec%0d RUNNING", i), d_running, vt[i].running);
      chk($sformatf("vec%0d FAULT", i), d_fault, vt[i].fault);
    end

    // Asynchronous reset between edges while running with nonzero state.
    #1 d_rst = 1'b1;
    #1;
    chk("async rst vC", d_vc, 0);
    chk("async rst iS", d_is, 0);
    chk("async rst Vo", d_vo, 0);
    chk("async rst RUNNING", d_running, 0);
    @(negedge CLK);
    d_rst = 1'b0; d_start = 1'b0; d_en = 1'b1; d_sigma = 2'b01;
    repeat (3) @(posedge CLK);
    #1;
    chk("no start iS", d_is, 0);
    chk("no start Vo", d_vo, 0);
    chk("no start RUNNING", d_running, 0);

    // Decimation by 4: VALID on steps 4 and 8.
    b_restart();
    b_en = 1'b1; b_sigma = 2'b01;
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("decim step%0d VALID", k + 1), q_valid, (k == 3 || k == 7) ? 1 : 0);
    end

    // Stop after 6 steps, restart: counter resumes, VALID after 2 more steps.
    b_restart();
    b_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("decim run1 step%0d VALID", k + 1), q_valid, (k == 3) ? 1 : 0);
    end
    @(negedge CLK);
    b_en = 1'b0; b_stop = 1'b1;
    @(negedge CLK);
    b_stop = 1'b0; b_start = 1'b1;
    chk("decim stopped RUNNING", q_running, 0);
    @(negedge CLK);
    b_start = 1'b0; b_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("decim resume step%0d VALID", k + 1), q_valid, (k == 1) ? 1 : 0);
    end

    // W=16 saturation into FAULT, then clear.
    b_restart();
    b_en = 1'b1; b_sigma = 2'b01;
    @(posedge CLK);
    #1;
    chk("w16 iS clipped", n_is, 32767);
    chk("w16 Vo", n_vo, 480);
    chk("w16 FAULT", n_fault, 1);
    chk("w16 RUNNING", n_running, 0);
    @(negedge CLK);
    b_start = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("w16 hold iS", n_is, 32767);
    chk("w16 hold Vo", n_vo, 480);
    chk("w16 hold VALID", n_valid, 0);
    chk("w16 hold FAULT", n_fault, 1);
    @(negedge CLK);
    b_start = 1'b0; b_en = 1'b0; b_clr = 1'b1;
    @(posedge CLK);
    #1;
    chk("w16 clr iS", n_is, 0);
    chk("w16 clr Vo", n_vo, 0);
    chk("w16 clr vC", n_vc, 0);
    chk("w16 clr FAULT", n_fault, 0);
    chk("w16 clr RUNNING", n_running, 0);
    @(negedge CLK);
    b_clr = 1'b0;

    // Series-LC mode: Vo pinned at zero.
    b_restart();
    b_en = 1'b1; b_sigma = 2'b01;
    @(posedge CLK);
    #1;
    chk("mode1 s1 iS", m_is, 48000);
    chk("mode1 s1 Vo", m_vo, 0);
    @(posedge CLK);
    #1;
    chk("mode1 s2 iS", m_is, 96000);
    chk("mode1 s2 Vo", m_vo, 0);
    @(posedge CLK);
    #1;
    chk("mode1 s3 vC", m_vc, 1);
    chk("mode1 s3 iS", m_is, 144000);
    @(negedge CLK);
    b_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
